axis_alex_rx: RTL

AXIS_ALEX_RX -- requirements
Module: axis_alex_rx

---
 rtl/axis_alex_rx.sv | 103 ++++++++++
 1 files changed

// File: rtl/axis_alex_rx.sv
// Serial "Alex" link receiver: 16-bit frames clocked by sclk,
// latched by load strobes, delivered as AXI4-Stream words.
module axis_alex_rx #(
    parameter int TIMEOUT = 160
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  alex_data,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        overflow,
    output logic [7:0]  err_cntr
);

    logic [3:0]  r_s1;
    logic [3:0]  r_s2;
    logic [3:0]  r_s3;
    logic [15:0] r_shift;
    logic [4:0]  r_bits;
    logic [11:0] r_idle;
    logic [17:0] r_word;
    logic        r_valid;
    logic        r_ovf;
    logic [7:0]  r_err;

    logic [3:0]  w_rise;
    logic        w_load_lvl;
    logic        w_load_ev;
    logic        w_bit;
    logic        w_timeout;
    logic        w_done;
    logic        w_bad;

    assign w_rise     = r_s2 & ~r_s3;
    assign w_load_lvl = r_s2[2] | r_s2[3];
    assign w_load_ev  = w_load_lvl & ~(r_s3[2] | r_s3[3]);
    // Any asserted load line masks sclk, so a load event always wins.
    assign w_bit      = w_rise[1] & ~w_load_lvl;
    assign w_timeout  = (r_bits != 5'd0) && (r_idle == 12'(TIMEOUT))
                        && !w_load_ev && !w_bit;
    assign w_done     = w_load_ev && (r_bits == 5'd16);
    assign w_bad      = (w_load_ev && (r_bits != 5'd0) && (r_bits != 5'd16))
                        || (w_timeout && (r_bits != 5'd16));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= alex_data;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_shift <= '0;
            r_bits  <= '0;
            r_idle  <= '0;
            r_err   <= '0;
        end else begin
            if (w_bit)
                r_shift <= {r_shift[14:0], r_s2[0]};
            if (w_load_ev || w_timeout)
                r_bits <= '0;
            else if (w_bit && (r_bits != 5'd31))
                r_bits <= r_bits + 5'd1;
            if ((r_bits == 5'd0) || w_bit || w_load_ev || w_timeout)
                r_idle <= '0;
            else
                r_idle <= r_idle + 12'd1;
            if (w_bad && (r_err != 8'hFF))
                r_err <= r_err + 8'd1;
        end
    end

    // One-word holding register; a word arriving while stalled is lost.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_word  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_done) begin
            if (!r_valid || m_axis_tready) begin
                r_word  <= {r_s2[3], r_s2[2], r_shift};
                r_valid <= 1'b1;
            end else begin
                r_ovf <= 1'b1;
            end
        end else if (m_axis_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign m_axis_tdata  = {14'd0, r_word};
    assign m_axis_tvalid = r_valid;
    assign overflow      = r_ovf;
    assign err_cntr      = r_err;

endmodule
